// File: rtl/alu_issue_ctrl.sv
// Issue controller for a single MIPS R-type ALU op: decodes a request, drives an
// external ALU for one cycle, and returns a held response with overflow trapping.
module alu_issue_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_funct,
    input  logic [31:0] req_rs_val,
    input  logic [31:0] req_rt_val,
    input  logic [4:0]  req_shamt,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_op,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    input  logic        alu_overflow,
    input  logic        alu_gtz,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_result,
    output logic        resp_zero,
    output logic        resp_gtz,
    output logic        resp_ovf_trap,
    output logic        resp_illegal,
    output logic [15:0] ops_done
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      state_q;
    logic [31:0] alu_a_q, alu_b_q;
    logic [2:0]  alu_op_q;
    logic        trap_en_q;
    logic        resp_valid_q, resp_zero_q, resp_gtz_q, resp_ovf_trap_q, resp_illegal_q;
    logic [31:0] resp_result_q;
    logic [15:0] ops_done_q;

    logic        legal_d, trap_en_d;
    logic [2:0]  alu_op_d;
    logic [31:0] alu_a_d, alu_b_d;

    // Decode straight from the request so operands are registered at the accept edge.
    always_comb begin
        legal_d   = 1'b1;
        trap_en_d = 1'b0;
        alu_op_d  = 3'b000;
        alu_a_d   = req_rs_val;
        alu_b_d   = req_rt_val;
        case (req_funct)
            6'h20: trap_en_d = 1'b1;
            6'h21: ;
            6'h22: begin alu_op_d = 3'b001; trap_en_d = 1'b1; end
            6'h23: alu_op_d = 3'b001;
            6'h24: alu_op_d = 3'b010;
            6'h25: alu_op_d = 3'b011;
            6'h26: alu_op_d = 3'b100;
            6'h27: alu_op_d = 3'b101;
            6'h00: begin alu_op_d = 3'b110; alu_a_d = req_rt_val; alu_b_d = {27'b0, req_shamt}; end
            6'h02: begin alu_op_d = 3'b111; alu_a_d = req_rt_val; alu_b_d = {27'b0, req_shamt}; end
            6'h04: begin alu_op_d = 3'b110; alu_a_d = req_rt_val; alu_b_d = req_rs_val; end
            6'h06: begin alu_op_d = 3'b111; alu_a_d = req_rt_val; alu_b_d = req_rs_val; end
            default: legal_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            alu_a_q         <= '0;
            alu_b_q         <= '0;
            alu_op_q        <= '0;
            trap_en_q       <= 1'b0;
            resp_valid_q    <= 1'b0;
            resp_result_q   <= '0;
            resp_zero_q     <= 1'b0;
            resp_gtz_q      <= 1'b0;
            resp_ovf_trap_q <= 1'b0;
            resp_illegal_q  <= 1'b0;
            ops_done_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        if (legal_d) begin
                            alu_a_q   <= alu_a_d;
                            alu_b_q   <= alu_b_d;
                            alu_op_q  <= alu_op_d;
                            trap_en_q <= trap_en_d;
                            state_q   <= EXEC;
                        end else begin
                            // Illegal ops skip EXEC; ALU operands keep their last value.
                            resp_valid_q    <= 1'b1;
                            resp_illegal_q  <= 1'b1;
                            resp_result_q   <= '0;
                            resp_zero_q     <= 1'b0;
                            resp_gtz_q      <= 1'b0;
                            resp_ovf_trap_q <= 1'b0;
                            state_q         <= RESP;
                        end
                    end
                end
                EXEC: begin
                    resp_valid_q    <= 1'b1;
                    resp_illegal_q  <= 1'b0;
                    resp_result_q   <= (alu_overflow && trap_en_q) ? 32'b0 : alu_result;
                    resp_zero_q     <= alu_zero;
                    resp_gtz_q      <= alu_gtz;
                    resp_ovf_trap_q <= alu_overflow && trap_en_q;
                    state_q         <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        ops_done_q   <= ops_done_q + 16'd1;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready     = (state_q == IDLE);
    assign alu_a         = alu_a_q;
    assign alu_b         = alu_b_q;
    assign alu_op        = alu_op_q;
    assign resp_valid    = resp_valid_q;
    assign resp_result   = resp_result_q;
    assign resp_zero     = resp_zero_q;
    assign resp_gtz      = resp_gtz_q;
    assign resp_ovf_trap = resp_ovf_trap_q;
    assign resp_illegal  = resp_illegal_q;
    assign ops_done      = ops_done_q;

endmodule
